msrv32_wb_stage: RTL and testbench

MSRV32_WB_STAGE -- requirements
Module: msrv32_wb_stage

---
 rtl/msrv32_pkg.sv | 15 +
 rtl/msrv32_integer_file.sv | 56 +++++
 rtl/msrv32_wb_stage.sv | 85 ++++++++
 tb/tb_msrv32_wb_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared widths and writeback source encodings for the msrv32 writeback slice.
package msrv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_CSR  = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/msrv32_integer_file.sv
// 32 x XLEN integer register file with x0 hardwired to zero and two async read ports.
// Optional write-to-read bypass when MSRV32_RF_BYPASS_EN is defined.
module msrv32_integer_file
  import msrv32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_in,
  input  logic [REG_ADDR_W-1:0] wr_addr_in,
  input  logic [XLEN-1:0]       wr_data_in,
  input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
  input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
  output logic [XLEN-1:0]       rs_1_out,
  output logic [XLEN-1:0]       rs_2_out
);

  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [XLEN-1:0] regs_q [NUM_REGS];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_in && (wr_addr_in != '0)) begin
      regs_d[wr_addr_in] = wr_data_in;
    end
    regs_d[0] = '0;
  end

  // NOTE: the whole array is cleared by reset because software relies on x1..x31 reading zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    logic [XLEN-1:0] data;
    data = (addr == '0) ? '0 : regs_q[addr];
`ifdef MSRV32_RF_BYPASS_EN
    if (wr_en_in && (addr != '0) && (addr == wr_addr_in)) begin
      data = wr_data_in;
    end
`endif
    return data;
  endfunction

  always_comb begin
    rs_1_out = read_port(rs_1_addr_in);
    rs_2_out = read_port(rs_2_addr_in);
  end

endmodule

// File: rtl/msrv32_wb_stage.sv
// Writeback stage: source mux, stage register and integer register file.
// Build option MSRV32_RF_BYPASS_EN enables write-to-read bypass in the register file.
module msrv32_wb_stage
  import msrv32_pkg::*;
(
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  input  logic [XLEN-1:0]       alu_result_in,
  input  logic [XLEN-1:0]       load_data_in,
  input  logic [XLEN-1:0]       pc_plus_4_in,
  input  logic [XLEN-1:0]       csr_data_in,
  input  logic [1:0]            wb_mux_sel_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  rf_wr_en_in,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic [REG_ADDR_W-1:0] rs_1_addr_in,
  input  logic [REG_ADDR_W-1:0] rs_2_addr_in,
  output logic [XLEN-1:0]       rs_1_out,
  output logic [XLEN-1:0]       rs_2_out,
  output logic [XLEN-1:0]       wb_data_out,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_out,
  output logic                  wb_valid_out
);

  logic [XLEN-1:0]       mux_data;
  logic [XLEN-1:0]       wb_data_d,    wb_data_q;
  logic [REG_ADDR_W-1:0] wb_rd_addr_d, wb_rd_addr_q;
  logic                  wb_valid_d,   wb_valid_q;

  always_comb begin
    mux_data = alu_result_in;
    case (wb_sel_e'(wb_mux_sel_in))
      WB_SEL_ALU:  mux_data = alu_result_in;
      WB_SEL_LOAD: mux_data = load_data_in;
      WB_SEL_PC4:  mux_data = pc_plus_4_in;
      WB_SEL_CSR:  mux_data = csr_data_in;
      default:     mux_data = alu_result_in;
    endcase
  end

  // Flush only kills the valid bit; data and address are don't-care and simply hold.
  always_comb begin
    wb_data_d    = wb_data_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_valid_d   = wb_valid_q;
    if (flush_in) begin
      wb_valid_d = 1'b0;
    end else if (!stall_in) begin
      wb_data_d    = mux_data;
      wb_rd_addr_d = rd_addr_in;
      wb_valid_d   = rf_wr_en_in && (rd_addr_in != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      wb_data_q    <= '0;
      wb_rd_addr_q <= '0;
      wb_valid_q   <= 1'b0;
    end else begin
      wb_data_q    <= wb_data_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_valid_q   <= wb_valid_d;
    end
  end

  assign wb_data_out    = wb_data_q;
  assign wb_rd_addr_out = wb_rd_addr_q;
  assign wb_valid_out   = wb_valid_q;

  msrv32_integer_file u_integer_file (
    .clk          (ms_riscv32_mp_clk_in),
    .rst_n        (ms_riscv32_mp_rst_in),
    .wr_en_in     (wb_valid_q),
    .wr_addr_in   (wb_rd_addr_q),
    .wr_data_in   (wb_data_q),
    .rs_1_addr_in (rs_1_addr_in),
    .rs_2_addr_in (rs_2_addr_in),
    .rs_1_out     (rs_1_out),
    .rs_2_out     (rs_2_out)
  );

endmodule

// File: tb/tb_msrv32_wb_stage.sv
// Directed self-checking bench for msrv32_wb_stage; expected values are hand-computed.
module tb_msrv32_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result, load_data, pc_plus_4, csr_data;
  logic [1:0]  wb_mux_sel;
  logic [4:0]  rd_addr, rs_1_addr, rs_2_addr;
  logic        rf_wr_en, stall, flush;
  logic [31:0] rs_1_out, rs_2_out, wb_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_valid;

  int n_vectors     = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  msrv32_wb_stage dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .alu_result_in        (alu_result),
    .load_data_in         (load_data),
    .pc_plus_4_in         (pc_plus_4),
    .csr_data_in          (csr_data),
    .wb_mux_sel_in        (wb_mux_sel),
    .rd_addr_in           (rd_addr),
    .rf_wr_en_in          (rf_wr_en),
    .stall_in             (stall),
    .flush_in             (flush),
    .rs_1_addr_in         (rs_1_addr),
    .rs_2_addr_in         (rs_2_addr),
    .rs_1_out             (rs_1_out),
    .rs_2_out             (rs_2_out),
    .wb_data_out          (wb_data),
    .wb_rd_addr_out       (wb_rd_addr),
    .wb_valid_out         (wb_valid)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_both(input logic [4:0] a1, input logic [4:0] a2);
    rs_1_addr = a1;
    rs_2_addr = a2;
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    alu_result = '0; load_data = '0; pc_plus_4 = '0; csr_data = '0;
    wb_mux_sel = 2'b00; rd_addr = '0; rf_wr_en = 1'b0;
    stall = 1'b0; flush = 1'b0; rs_1_addr = '0; rs_2_addr = '0;

    // Reset for one edge, then every register reads zero on both ports.
    tick();
    rst_n = 1'b1;
    check("rst_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_rd", {27'd0, wb_rd_addr}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      read_both(5'(i), 5'(31 - i));
      check($sformatf("rst_rs1_x%0d", i), rs_1_out, 32'd0);
      check($sformatf("rst_rs2_x%0d", 31 - i), rs_2_out, 32'd0);
    end

    // ALU write to x5, read during the write cycle and after.
    alu_result = 32'hDEAD_BEEF; wb_mux_sel = 2'b00; rd_addr = 5'd5; rf_wr_en = 1'b1;
    read_both(5'd5, 5'd0);
    tick();
    rf_wr_en = 1'b0;
    #1;
    check("alu_wb_data", wb_data, 32'hDEAD_BEEF);
    check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("alu_wb_rd", {27'd0, wb_rd_addr}, 32'd5);
`ifdef MSRV32_RF_BYPASS_EN
    check("x5_write_cycle", rs_1_out, 32'hDEAD_BEEF);
`else
    check("x5_write_cycle", rs_1_out, 32'd0);
`endif
    tick();
    read_both(5'd5, 5'd5);
    check("x5_rs1", rs_1_out, 32'hDEAD_BEEF);
    check("x5_rs2", rs_2_out, 32'hDEAD_BEEF);
    check("idle_valid", {31'd0, wb_valid}, 32'd0);

    // Load source to x2, then CSR source to x3 back to back.
    load_data = 32'hA5A5_0001; wb_mux_sel = 2'b01; rd_addr = 5'd2; rf_wr_en = 1'b1;
    tick();
    check("load_wb_data", wb_data, 32'hA5A5_0001);
    csr_data = 32'h0000_0300; wb_mux_sel = 2'b11; rd_addr = 5'd3;
    tick();
    check("csr_wb_data", wb_data, 32'h0000_0300);
    check("csr_wb_rd", {27'd0, wb_rd_addr}, 32'd3);
    rf_wr_en = 1'b0;
    tick();
    read_both(5'd2, 5'd3);
    check("x2_load", rs_1_out, 32'hA5A5_0001);
    check("x3_csr", rs_2_out, 32'h0000_0300);

    // Writes to x0 and writes with enable low never become valid.
    alu_result = 32'h0000_1234; wb_mux_sel = 2'b00; rd_addr = 5'd0; rf_wr_en = 1'b1;
    tick();
    check("x0_wr_valid", {31'd0, wb_valid}, 32'd0);
    rd_addr = 5'd9; rf_wr_en = 1'b0;
    tick();
    check("no_en_valid", {31'd0, wb_valid}, 32'd0);
    read_both(5'd0, 5'd9);
    check("x0_reads_zero", rs_1_out, 32'd0);
    check("x9_unwritten", rs_2_out, 32'd0);

    // pc+4 to x1, held through a 3-cycle stall, then flush together with stall.
    pc_plus_4 = 32'h0000_0104; wb_mux_sel = 2'b10; rd_addr = 5'd1; rf_wr_en = 1'b1;
    tick();
    check("pc4_wb_data", wb_data, 32'h0000_0104);
    stall = 1'b1; wb_mux_sel = 2'b00; alu_result = 32'h0000_FFFF; rd_addr = 5'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_data", i), wb_data, 32'h0000_0104);
      check($sformatf("stall%0d_rd", i), {27'd0, wb_rd_addr}, 32'd1);
      check($sformatf("stall%0d_valid", i), {31'd0, wb_valid}, 32'd1);
    end
    flush = 1'b1;
    tick();
    check("flush_valid", {31'd0, wb_valid}, 32'd0);
    flush = 1'b0; stall = 1'b0; rf_wr_en = 1'b0;
    read_both(5'd1, 5'd4);
    check("x1_pc4", rs_1_out, 32'h0000_0104);
    check("x4_not_written", rs_2_out, 32'd0);

    // Reset at the commit edge of a pending write to x7 discards it.
    alu_result = 32'h0000_0077; wb_mux_sel = 2'b00; rd_addr = 5'd7; rf_wr_en = 1'b1;
    tick();
    check("x7_pending_valid", {31'd0, wb_valid}, 32'd1);
    rst_n = 1'b0; rf_wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_valid", {31'd0, wb_valid}, 32'd0);
    check("rst2_data", wb_data, 32'd0);
    check("rst2_rd", {27'd0, wb_rd_addr}, 32'd0);
    read_both(5'd7, 5'd5);
    check("x7_discarded", rs_1_out, 32'd0);
    check("x5_cleared", rs_2_out, 32'd0);
    tick();
    check("x7_still_zero", rs_1_out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
